// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared types and ASCII constants for the expression transmitter/recognizer
//
// Purpose : FSM state encoding, ASCII byte values for digits and operators,
//           operator bit encoding and small byte-formatting helpers.
// Ports   : none (package)
package expr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_MUL  = 8'h2A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'b0000, d};
  endfunction

  function automatic logic [7:0] op_char(input logic op);
    return (op == OP_MUL) ? ASCII_MUL : ASCII_PLUS;
  endfunction

endpackage

// File: rtl/expr_tx_eval.sv
// rtl/expr_tx_eval.sv - left-to-right accumulator for the transmitted expression
//
// Purpose : evaluates the expression as digits are accepted, strictly left to
//           right with no precedence, modulo 2^16.
// Ports   : clk, clr (async, active-high)
//           accept  - a DIGIT byte is consumed this cycle
//           first   - the consumed digit is term 0 (loads the accumulator)
//           mul     - operator preceding the consumed digit is '*'
//           digit   - BCD value of the consumed digit
//           result  - running value
module expr_tx_eval
  import expr_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        accept,
  input  logic        first,
  input  logic        mul,
  input  logic [3:0]  digit,
  output logic [15:0] result
);

  logic [15:0] d16;
  assign d16 = {12'h000, digit};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      result <= 16'h0000;
    end else if (accept) begin
      if (first)
        result <= d16;
      else if (mul == OP_MUL)
        result <= result * d16;
      else
        result <= result + d16;
    end
  end

endmodule

// File: rtl/expr_tx.sv
// rtl/expr_tx.sv - serialises a BCD digit/operator expression as an ASCII byte stream
//
// Purpose : on start, captures up to MAX_TERMS digits plus operators and emits
//           them as "d(op d)*" in ASCII, one byte per handshake, then pulses done.
//           Rejected starts (too many terms or a used digit > 9) pulse err.
// Ports   : clk, clr (async, active-high)
//           start, n_terms[3:0] (count-1), digits[4*MAX_TERMS-1:0], ops[MAX_TERMS-2:0]
//           out[7:0], out_valid, out_ready - byte stream handshake
//           busy, done, err - status
//           result[15:0], result_valid - only when EXPR_TX_EVAL_EN is defined
// Config  : EXPR_TX_EVAL_EN adds the left-to-right evaluator outputs.
module expr_tx
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [3:0]             n_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
`ifdef EXPR_TX_EVAL_EN
  ,
  output logic [15:0]            result,
  output logic                   result_valid
`endif
);

  // Operands are widened to 16 slots so a 4-bit index always selects in range;
  // slots beyond MAX_TERMS read as zero.
  logic [15:0][3:0] dig_in;
  logic [15:0]      ops_in;
  logic [15:0][3:0] dig_reg;
  logic [15:0]      ops_reg;
  logic [3:0]       n_reg;
  logic [3:0]       idx;
  state_t           state;

  logic too_many;
  logic bad_digit;

  always_comb begin
    dig_in = '0;
    ops_in = '0;
    for (int i = 0; i < MAX_TERMS; i++)
      dig_in[i] = digits[4*i +: 4];
    for (int i = 0; i < MAX_TERMS - 1; i++)
      ops_in[i] = ops[i];
  end

  assign too_many = (32'(n_terms) >= MAX_TERMS);

  // Only digits that will actually be sent are range-checked.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < 16; i++)
      if ((4'(i) <= n_terms) && (dig_in[i] > 4'd9))
        bad_digit = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      idx       <= 4'd0;
      n_reg     <= 4'd0;
      dig_reg   <= '0;
      ops_reg   <= '0;
      out       <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (too_many || bad_digit) begin
              err <= 1'b1;
            end else begin
              n_reg     <= n_terms;
              dig_reg   <= dig_in;
              ops_reg   <= ops_in;
              idx       <= 4'd0;
              state     <= DIGIT;
              out       <= digit_char(dig_in[0]);
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        DIGIT: begin
          if (out_ready) begin
            if (idx == n_reg) begin
              state     <= FIN;
              out       <= 8'h00;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              // Operator between term idx and idx+1 follows this digit.
              idx   <= idx + 4'd1;
              state <= OP;
              out   <= op_char(ops_reg[idx]);
            end
          end
        end
        OP: begin
          if (out_ready) begin
            state <= DIGIT;
            out   <= digit_char(dig_reg[idx]);
          end
        end
        FIN: begin
          state <= IDLE;
          idx   <= 4'd0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXPR_TX_EVAL_EN
  logic [3:0] prev_idx;
  assign prev_idx = idx - 4'd1;

  expr_tx_eval u_eval (
    .clk    (clk),
    .clr    (clr),
    .accept ((state == DIGIT) && out_ready),
    .first  (idx == 4'd0),
    .mul    (ops_reg[prev_idx]),
    .digit  (dig_reg[idx]),
    .result (result)
  );

  assign result_valid = done;
`endif

endmodule

// File: doc/expr_tx.md
EXPR_TX -- requirements
Module: expr_tx

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 8, meaning maximum digit operands per expression (range 2..16).
REQ-002 SHALL have port clk  input  1  clock, rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to transmit one expression.
REQ-005 SHALL have port n_terms  input  4  operand count minus one (0 => one digit).
REQ-006 SHALL have port digits  input  4*MAX_TERMS  packed BCD operands, term 0 in bits [3:0].
REQ-007 SHALL have port ops  input  MAX_TERMS-1  operator per gap, bit i between term i and i+1; 0 = '+', 1 = '*'.
REQ-008 SHALL have port out  output  8  ASCII byte.
REQ-009 SHALL have port out_valid  output  1  out holds a valid byte.
REQ-010 SHALL have port out_ready  input  1  downstream accepts byte this cycle.
REQ-011 SHALL have port busy  output  1  transmission in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse after last byte accepted.
REQ-013 SHALL have port err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-014 SHALL use FSM states IDLE, DIGIT, OP, FIN.
REQ-015 In IDLE, start=1 SHALL capture n_terms, digits, ops into internal registers and enter DIGIT next cycle with term index 0.
REQ-016 start SHALL be rejected (err=1 next cycle, stay IDLE, nothing sent) if n_terms+1 > MAX_TERMS or any used digit > 9.
REQ-017 In DIGIT, out SHALL be 8'h30 + digit[index], out_valid=1.
REQ-018 In OP, out SHALL be 8'h2B ('+') or 8'h2A ('*') per ops[index-1], out_valid=1.
REQ-019 A byte SHALL be consumed only on a cycle with out_valid=1 and out_ready=1; otherwise out and state SHALL hold unchanged.
REQ-020 On a DIGIT handshake: if index == captured n_terms go to FIN, else increment index and go to OP.
REQ-021 On an OP handshake go to DIGIT.
REQ-022 FIN SHALL assert done=1 for exactly one cycle with out_valid=0, then return to IDLE.
REQ-023 Throughput SHALL be one byte per cycle when out_ready stays 1; first byte valid the cycle after start; a K-term expression occupies 2K-1 byte cycles plus one FIN cycle.
REQ-024 busy SHALL be 1 in DIGIT, OP, FIN; start while busy SHALL be ignored (no err).
REQ-025 Changes on digits/ops/n_terms after capture SHALL not affect the stream.
REQ-026 Emitted stream SHALL always be digit ( op digit )*, never beginning or ending with an operator.

Reset
REQ-027 clr=1 SHALL immediately force IDLE, index 0, out=8'h00, out_valid=0, busy=0, done=0, err=0.
REQ-028 clr mid-transmission SHALL abort without done; clr SHALL dominate start.

Configuration
REQ-029 With EXPR_TX_EVAL_EN defined, SHALL add output result[15:0] and result_valid: operands evaluated strictly left-to-right (no precedence), modulo 2^16, updated per accepted DIGIT; result_valid=1 coincident with done.
REQ-030 Without EXPR_TX_EVAL_EN, result and result_valid ports and logic SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package expr_pkg SHALL hold state enum, ASCII constants ('0', '+', '*') and operator encoding, shared with the recognizer side.
REQ-032 Sub-module expr_tx_eval (accumulator, EVAL feature) is natural; instantiated only under EXPR_TX_EVAL_EN.

Verification
REQ-033 n_terms=2, digits 3,4,5, ops=2'b10, out_ready=1 -> bytes "3","+","4","*","5" (33,2B,34,2A,35) on consecutive cycles, done next cycle; EVAL: result=35.
REQ-034 Same stimulus, out_ready low for 3 cycles during '+' -> 2B held stable with out_valid=1, stream otherwise unchanged.
REQ-035 n_terms=0, digit 7 -> single byte 37, done; start with digit 4'hA in use -> err pulse, no out_valid.
REQ-036 clr asserted after second byte -> out_valid=0 immediately, no done; next start sends full expression from term 0.
REQ-037 start pulsed while busy, inputs changed -> ignored, original stream completes.
REQ-038 Stream looped into the existing recognizer -> recognizer output 1 after every emitted digit, never enters failed state.
